bcd_to_binary_seq: RTL and testbench

Sequential, parametrised N-digit packed-BCD to binary converter for the microwave controller's time-entry path. It replaces the single-digit combinational converter: keypad digits held as packed BCD (e.g. MM:SS as 4 digits) are converted to one binary count with a start/busy/done handshake. The block processes one digit per clock and flags invalid digits and result overflow. The timer/countdown logic consumes `bin_out` on `done`.

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_mac10.sv | 24 ++
 rtl/bcd_to_binary_seq.sv | 109 ++++++++++
 tb/tb_bcd_to_binary_seq.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential packed-BCD to binary converter.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int BCD_MAX = 9;
   localparam int RADIX   = 10;

   // Smallest binary width that holds every value of a 'digits'-digit BCD number.
   function automatic int bcd_bin_width(input int digits);
      longint p;
      p = 1;
      for (int i = 0; i < digits; i++) p = p * RADIX;
      return $clog2(p);
   endfunction

endpackage

// File: rtl/bcd_mac10.sv
// Combinational acc*10 + digit step with saturation, overflow and invalid-digit flags.
module bcd_mac10
   import bcd_pkg::*;
#(
   parameter int BIN_W = 14
) (
   input  logic [BIN_W-1:0] acc,
   input  logic [3:0]       digit,
   output logic [BIN_W-1:0] result,
   output logic             ovf,
   output logic             bad
);

   localparam int W = BIN_W + 4;

   logic [W-1:0] wide;

   // Four guard bits hold any (2^BIN_W-1)*10 + 9 without wrapping.
   assign wide   = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1) + W'(digit);
   assign ovf    = |wide[W-1:BIN_W];
   assign result = ovf ? '1 : wide[BIN_W-1:0];
   assign bad    = digit > 4'(BCD_MAX);

endmodule

// File: rtl/bcd_to_binary_seq.sv
// N-digit packed-BCD to binary converter, one digit per clock, MSB digit first,
// with start/busy/done handshake, invalid-digit abort and saturating overflow.
module bcd_to_binary_seq
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  busy,
   output logic                  done,
   output logic [BIN_W-1:0]      bin_out,
   output logic                  err,
   output logic                  ovf
);

   localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_t              state;
   logic [4*DIGITS-1:0] shreg;
   logic [CNT_W-1:0]    cnt;
   logic [BIN_W-1:0]    acc;
   logic                ovf_seen;

   logic [3:0]          digit;
   logic [BIN_W-1:0]    acc_next;
   logic                mac_ovf;
   logic                mac_bad;

   assign digit = shreg[4*DIGITS-1 -: 4];

   bcd_mac10 #(.BIN_W(BIN_W)) u_mac (
      .acc    (acc),
      .digit  (digit),
      .result (acc_next),
      .ovf    (mac_ovf),
      .bad    (mac_bad)
   );

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         shreg    <= '0;
         cnt      <= '0;
         acc      <= '0;
         ovf_seen <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         bin_out  <= '0;
         err      <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  shreg    <= bcd_in;
                  cnt      <= CNT_W'(DIGITS - 1);
                  acc      <= '0;
                  ovf_seen <= 1'b0;
                  bin_out  <= '0;
                  err      <= 1'b0;
                  ovf      <= 1'b0;
                  busy     <= 1'b1;
                  state    <= CONV;
               end
            end

            CONV: begin
               if (mac_bad) begin
                  // Abort: only overflow from earlier digits is reported.
                  bin_out <= '0;
                  err     <= 1'b1;
                  ovf     <= ovf_seen;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= DONE;
               end else begin
                  acc      <= acc_next;
                  ovf_seen <= ovf_seen | mac_ovf;
                  shreg    <= shreg << 4;
                  if (cnt == '0) begin
                     bin_out <= acc_next;
                     ovf     <= ovf_seen | mac_ovf;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     state   <= DONE;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
            end

            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench: two instances (default width and a narrow saturating one)
// driven in lockstep and compared with a digit-by-digit arithmetic model.
module tb_bcd_to_binary_seq;
   import bcd_pkg::*;

   localparam int DIG = 4;
   localparam int W14 = bcd_bin_width(DIG);
   localparam int W10 = 10;

   logic            clk;
   logic            rst;
   logic            start;
   logic [15:0]     bcd_in;

   logic            busy14, done14, err14, ovf14;
   logic [W14-1:0]  bin14;
   logic            busy10, done10, err10, ovf10;
   logic [W10-1:0]  bin10;

   int n_pass;
   int n_total;

   // Results captured by do_conv
   int             done_cyc, done_cyc10, busy_cyc, done_cnt;
   logic [W14-1:0] r_bin14;
   logic           r_err14, r_ovf14;
   logic [W10-1:0] r_bin10;
   logic           r_err10, r_ovf10;

   bcd_to_binary_seq #(.DIGITS(DIG), .BIN_W(W14)) dut (
      .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
      .busy(busy14), .done(done14), .bin_out(bin14), .err(err14), .ovf(ovf14)
   );

   bcd_to_binary_seq #(.DIGITS(DIG), .BIN_W(W10)) dut10 (
      .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
      .busy(busy10), .done(done10), .bin_out(bin10), .err(err10), .ovf(ovf10)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: MSB digit first; invalid digit aborts with zero, overflow clamps.
   function automatic void ref_model(input logic [15:0] bcd, input int w,
                                     output longint bin, output bit e,
                                     output bit o, output int n);
      longint acc, maxv;
      int d;
      logic [15:0] v;
      v = bcd;
      maxv = (longint'(1) << w) - 1;
      acc = 0; e = 0; o = 0; n = 0;
      for (int i = DIG - 1; i >= 0; i--) begin
         d = int'(v[4*i +: 4]);
         n++;
         if (d > 9) begin
            e = 1;
            acc = 0;
            break;
         end
         acc = acc * 10 + d;
         if (acc > maxv) begin
            acc = maxv;
            o = 1;
         end
      end
      bin = acc;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_conv(input logic [15:0] bcd);
      bcd_in = bcd;
      start  = 1'b1;
      step();
      start  = 1'b0;
      bcd_in = 16'($urandom);
      done_cyc = 0; done_cyc10 = 0; busy_cyc = 0; done_cnt = 0;
      for (int c = 1; c <= 12; c++) begin
         if (busy14) busy_cyc++;
         if (done14) begin
            done_cnt++;
            if (done_cyc == 0) done_cyc = c;
            r_bin14 = bin14; r_err14 = err14; r_ovf14 = ovf14;
         end
         if (done10) begin
            if (done_cyc10 == 0) done_cyc10 = c;
            r_bin10 = bin10; r_err10 = err10; r_ovf10 = ovf10;
         end
         step();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; bcd_in = '0;
      repeat (3) step();
      n_total++; if (busy14 !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy14); else n_pass++;
      n_total++; if (done14 !== 1'b0) $display("FAIL reset_done got=%b want=0", done14); else n_pass++;
      n_total++; if (bin14 !== '0) $display("FAIL reset_bin got=%0d want=0", bin14); else n_pass++;
      n_total++; if (err14 !== 1'b0) $display("FAIL reset_err got=%b want=0", err14); else n_pass++;
      n_total++; if (ovf14 !== 1'b0) $display("FAIL reset_ovf got=%b want=0", ovf14); else n_pass++;
      n_total++; if ({busy10, done10, err10, ovf10, bin10} !== '0)
         $display("FAIL reset_narrow got=%b want=0", {busy10, done10, err10, ovf10, bin10}); else n_pass++;
      rst = 1'b0;
      step();
   endtask

   task automatic test_single_digit();
      do_conv(16'h0001);
      n_total++; if (done_cyc != 5) $display("FAIL single_latency got=%0d want=5", done_cyc); else n_pass++;
      n_total++; if (r_bin14 !== 14'd1) $display("FAIL single_bin got=%0d want=1", r_bin14); else n_pass++;
      n_total++; if ({r_err14, r_ovf14} !== 2'b00) $display("FAIL single_flags got=%b want=00", {r_err14, r_ovf14}); else n_pass++;
      n_total++; if (done_cnt != 1) $display("FAIL single_done_count got=%0d want=1", done_cnt); else n_pass++;
   endtask

   task automatic test_multi_digit();
      do_conv(16'h1234);
      n_total++; if (r_bin14 !== 14'd1234) $display("FAIL multi_1234 got=%0d want=1234", r_bin14); else n_pass++;
      n_total++; if (busy_cyc != 4) $display("FAIL multi_busy_1234 got=%0d want=4", busy_cyc); else n_pass++;
      n_total++; if (bin14 !== 14'd1234) $display("FAIL multi_hold got=%0d want=1234", bin14); else n_pass++;
      do_conv(16'h9999);
      n_total++; if (r_bin14 !== 14'd9999) $display("FAIL multi_9999 got=%0d want=9999", r_bin14); else n_pass++;
      n_total++; if (r_ovf14 !== 1'b0) $display("FAIL multi_9999_ovf got=%b want=0", r_ovf14); else n_pass++;
      n_total++; if (busy_cyc != 4) $display("FAIL multi_busy_9999 got=%0d want=4", busy_cyc); else n_pass++;
      n_total++; if ({r_ovf10, r_bin10} !== {1'b1, 10'd1023})
         $display("FAIL narrow_9999 got=%b/%0d want=1/1023", r_ovf10, r_bin10); else n_pass++;
   endtask

   task automatic test_invalid_digit();
      do_conv(16'h0A00);
      n_total++; if (done_cyc != 3) $display("FAIL invalid_latency got=%0d want=3", done_cyc); else n_pass++;
      n_total++; if (r_err14 !== 1'b1) $display("FAIL invalid_err got=%b want=1", r_err14); else n_pass++;
      n_total++; if (r_bin14 !== '0) $display("FAIL invalid_bin got=%0d want=0", r_bin14); else n_pass++;
      do_conv(16'h0010);
      n_total++; if (r_bin14 !== 14'd10) $display("FAIL after_invalid_bin got=%0d want=10", r_bin14); else n_pass++;
      n_total++; if (r_err14 !== 1'b0) $display("FAIL after_invalid_err got=%b want=0", r_err14); else n_pass++;
   endtask

   task automatic test_overflow();
      do_conv(16'h1234);
      n_total++; if (r_bin10 !== 10'd1023) $display("FAIL ovf_bin got=%0d want=1023", r_bin10); else n_pass++;
      n_total++; if (r_ovf10 !== 1'b1) $display("FAIL ovf_flag got=%b want=1", r_ovf10); else n_pass++;
      n_total++; if (done_cyc10 != 5) $display("FAIL ovf_latency got=%0d want=5", done_cyc10); else n_pass++;
   endtask

   task automatic test_start_while_busy();
      int cnt;
      logic [W14-1:0] b;
      cnt = 0; b = '0;
      bcd_in = 16'h1234; start = 1'b1;
      step();
      start = 1'b0; bcd_in = 16'h0000;
      step();
      start = 1'b1; bcd_in = 16'h5678;
      step();
      start = 1'b0;
      for (int c = 3; c < 14; c++) begin
         if (done14) begin cnt++; b = bin14; end
         step();
      end
      n_total++; if (cnt != 1) $display("FAIL busy_start_done_count got=%0d want=1", cnt); else n_pass++;
      n_total++; if (b !== 14'd1234) $display("FAIL busy_start_bin got=%0d want=1234", b); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int cnt;
      cnt = 0;
      bcd_in = 16'h1234; start = 1'b1;
      step();
      start = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (done14 || done10) cnt++;
         step();
      end
      n_total++; if (cnt != 0) $display("FAIL rst_mid_done got=%0d want=0", cnt); else n_pass++;
      n_total++; if ({busy14, err14, ovf14, bin14} !== '0)
         $display("FAIL rst_mid_outputs got=%b want=0", {busy14, err14, ovf14, bin14}); else n_pass++;
      do_conv(16'h0042);
      n_total++; if (r_bin14 !== 14'd42) $display("FAIL rst_mid_next got=%0d want=42", r_bin14); else n_pass++;
      n_total++; if (done_cyc != 5) $display("FAIL rst_mid_latency got=%0d want=5", done_cyc); else n_pass++;
   endtask

   task automatic test_back_to_back();
      bit seen;
      int dc;
      seen = 0; dc = 0;
      bcd_in = 16'h0777; start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 12 && !seen; c++) begin
         if (done14) seen = 1;
         step();
      end
      n_total++; if (!seen) $display("FAIL b2b_first_done got=none want=pulse"); else n_pass++;
      // one cycle after done: IDLE, result still held
      n_total++; if (bin14 !== 14'd777) $display("FAIL b2b_hold got=%0d want=777", bin14); else n_pass++;
      bcd_in = 16'h0056; start = 1'b1;
      step();
      start = 1'b0;
      n_total++; if (busy14 !== 1'b1) $display("FAIL b2b_accept got=%b want=1", busy14); else n_pass++;
      n_total++; if (bin14 !== '0) $display("FAIL b2b_clear got=%0d want=0", bin14); else n_pass++;
      for (int c = 1; c <= 10; c++) begin
         if (done14 && dc == 0) begin
            dc = c;
            r_bin14 = bin14;
         end
         step();
      end
      n_total++; if (dc != 5) $display("FAIL b2b_latency got=%0d want=5", dc); else n_pass++;
      n_total++; if (r_bin14 !== 14'd56) $display("FAIL b2b_bin got=%0d want=56", r_bin14); else n_pass++;
   endtask

   task automatic test_random();
      logic [15:0] v;
      longint eb14, eb10;
      bit ee14, eo14, ee10, eo10;
      int n14, n10;
      for (int it = 0; it < 30; it++) begin
         for (int i = 0; i < DIG; i++)
            v[4*i +: 4] = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 9))
                                                     : 4'($urandom_range(10, 15));
         ref_model(v, W14, eb14, ee14, eo14, n14);
         ref_model(v, W10, eb10, ee10, eo10, n10);
         do_conv(v);
         n_total++; if (done_cyc != n14 + 1)
            $display("FAIL rnd_latency bcd=%h got=%0d want=%0d", v, done_cyc, n14 + 1); else n_pass++;
         n_total++; if ({r_err14, r_ovf14, r_bin14} !== {ee14, eo14, W14'(eb14)})
            $display("FAIL rnd_wide bcd=%h got=%b/%b/%0d want=%b/%b/%0d", v, r_err14, r_ovf14, r_bin14, ee14, eo14, eb14);
         else n_pass++;
         n_total++; if ({r_err10, r_ovf10, r_bin10} !== {ee10, eo10, W10'(eb10)})
            $display("FAIL rnd_narrow bcd=%h got=%b/%b/%0d want=%b/%b/%0d", v, r_err10, r_ovf10, r_bin10, ee10, eo10, eb10);
         else n_pass++;
      end
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      test_reset();
      test_single_digit();
      test_multi_digit();
      test_invalid_digit();
      test_overflow();
      test_start_while_busy();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
